simon_seq_engine: RTL and testbench
===================================

# simon_seq_engine

Parametrised sequence-memory game engine, the next generation of the team's Simon controller. It grows a pseudo-random key sequence one step per round, plays it back to the display/sound front end, then checks player key presses against it. Timeout and win detection are built in. It sits between the button debouncers (key events) and the LED/tone drivers (playback events), clocked by the 60 Hz game tick.

## Interface
- `NUM_KEYS`, 4: number of distinct keys; must be ≥2. `KW = max(1, $clog2(NUM_KEYS))`.
- `MAX_LEN`, 16: maximum sequence length; reaching it ends the game as a win. `LW = $clog2(MAX_LEN+1)`.
- `SHOW_TICKS`, 30: cycles `show_valid` stays high per playback step; must be ≥2.
- `GAP_TICKS`, 30: dark cycles after each playback step; must be ≥2.
- `TIMEOUT_TICKS`, 120: idle cycles allowed between player keys in LISTEN.
- `SEED`, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- `clk` in 1: game tick.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: one-cycle pulse that begins a new game.
- `key_valid` in 1: one-cycle pulse marking a player key press.
- `key_idx` in KW: key pressed; qualified by `key_valid`.
- `show_valid` out 1: a playback key is lit.
- `show_idx` out KW: key being played back; held at 0 when `show_valid` is 0.
- `simon_turn` out 1: engine is appending or playing back.
- `level` out LW: current sequence length.
- `game_over` out 1: game has ended (win or lose).
- `win` out 1: game ended by completing `MAX_LEN`.

## Operation
States: IDLE, APPEND, SHOW_ON, SHOW_OFF, LISTEN, WIN, LOSE.
- **IDLE** (reset state): `start` → APPEND with `level` = 0.
- **APPEND** (1 cycle): `mem[level]` ← `rnd`; `level`++; step index `idx` ← 0; → SHOW_ON.
- **SHOW_ON**: `show_valid` = 1 and `show_idx` = `mem[idx]` for SHOW_TICKS cycles; then → SHOW_OFF.
- **SHOW_OFF**: lasts GAP_TICKS cycles. Then, if `idx == level-1`, → LISTEN with `idx` = 0 and timer = 0. Otherwise `idx`++ and → SHOW_ON.
- **LISTEN**, on `key_valid`:
  - `key_idx == mem[idx]` and `idx == level-1`: → WIN if `level == MAX_LEN`, else → APPEND.
  - `key_idx == mem[idx]` otherwise: `idx`++ and timer ← 0.
  - Mismatch, including `key_idx ≥ NUM_KEYS`: → LOSE.
- **LISTEN**, no key: timer++; when the timer reaches TIMEOUT_TICKS-1 → LOSE.
- **WIN/LOSE**: terminal; `game_over` = 1, and `win` = 1 in WIN only. `start` → APPEND with `level` reset to 0 (new game).
- `start` is ignored in APPEND/SHOW/LISTEN. `key_valid` is ignored outside LISTEN.
- `simon_turn` = 1 in APPEND, SHOW_ON and SHOW_OFF.
- Random source: 16-bit Galois LFSR, taps 16'hB400, advances every cycle, loads SEED on reset.
  - `r` = `lfsr[KW-1:0]`; `rnd` = `r ≥ NUM_KEYS ? r - NUM_KEYS : r`.
- `mem` is MAX_LEN×KW registers; it is not cleared on reset or new game.

## Timing
- Reset values: `show_valid`=0, `show_idx`=0, `simon_turn`=0, `level`=0, `game_over`=0, `win`=0; state IDLE; counters 0.
- Reset asserted mid-game aborts immediately to IDLE with all of the above.
- All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.
- `start` sampled at edge N → APPEND during cycle N+1 → `show_valid` high from cycle N+2 for SHOW_TICKS cycles.
- Playback of length L occupies L×(SHOW_TICKS+GAP_TICKS) cycles.
- A correct final key at edge N → APPEND at N+1, so the next playback starts at N+2.
- A key arriving on the same cycle the timer expires takes priority over the timeout.
- `level` saturates at MAX_LEN; it never wraps.

## Configuration
`SIMON_SPEEDUP_EN` selects a difficulty ramp.
- Defined: while `level > MAX_LEN/2`, SHOW and GAP durations become `SHOW_TICKS/2` and `GAP_TICKS/2` (floor, minimum 1).
- Undefined: durations are fixed for the whole game.
- Timeout is unaffected either way.

## Structure
- Package `simon_pkg`: state enum `simon_state_t`, LFSR tap constant `SIMON_LFSR_TAPS`.
- Sub-module `simon_lfsr` (parameter SEED; ports clk, reset, `lfsr[15:0]`).
- The FSM, sequence memory and counters stay in `simon_seq_engine`.

## Test plan
- Reset, then `start` → first `show_valid` rises exactly 2 cycles later, lasts 30 cycles, and `level` = 1.
- Replay every shown index correctly for 3 rounds → `level` = 4, and the playback of round 4 repeats the first 3 indices unchanged.
- Wrong `key_idx` on the 2nd key of round 2 → LOSE next cycle: `game_over` = 1, `win` = 0.
- No key for 120 cycles in LISTEN → `game_over` asserts; a key at cycle 119 instead keeps the game alive.
- With `MAX_LEN` = 2 and perfect play → `win` = 1 and `game_over` = 1; a subsequent `start` restarts with `level` = 1.
- With `NUM_KEYS` = 3, run 200 rounds with a model → `show_idx` is never 3. Also assert `reset` mid-SHOW_ON → `show_valid` drops immediately.

Source files
------------

// File: rtl/simon_pkg.sv
// ------------------------------------------------------------------
// simon_pkg: shared state encoding and LFSR helpers for the Simon engine.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package simon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_APPEND   = 3'd1,
    ST_SHOW_ON  = 3'd2,
    ST_SHOW_OFF = 3'd3,
    ST_LISTEN   = 3'd4,
    ST_WIN      = 3'd5,
    ST_LOSE     = 3'd6
  } simon_state_t;

  localparam logic [15:0] SIMON_LFSR_TAPS = 16'hB400;

  // Right-shifting Galois step: feedback bit is the LSB shifted out.
  function automatic logic [15:0] simon_lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ SIMON_LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/simon_lfsr.sv
// ------------------------------------------------------------------
// simon_lfsr: free-running 16-bit Galois LFSR, loads SEED on reset.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module simon_lfsr
  import simon_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] lfsr
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= SEED;
    else       lfsr_q <= simon_lfsr_next(lfsr_q);
  end

  assign lfsr = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/simon_seq_engine.sv
// ------------------------------------------------------------------
// simon_seq_engine: grows, plays back and checks a random key sequence.
// SIMON_SPEEDUP_EN halves playback timing once level passes MAX_LEN/2. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module simon_seq_engine
  import simon_pkg::*;
#(
  parameter int          NUM_KEYS      = 4,
  parameter int          MAX_LEN       = 16,
  parameter int          SHOW_TICKS    = 30,
  parameter int          GAP_TICKS     = 30,
  parameter int          TIMEOUT_TICKS = 120,
  parameter logic [15:0] SEED          = 16'hACE1,
  localparam int         KW            = (NUM_KEYS > 2) ? $clog2(NUM_KEYS) : 1,
  localparam int         LW            = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          key_valid,
  input  logic [KW-1:0] key_idx,
  output logic          show_valid,
  output logic [KW-1:0] show_idx,
  output logic          simon_turn,
  output logic [LW-1:0] level,
  output logic          game_over,
  output logic          win
);

  localparam int AW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMAX_A = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int TMAX   = (TMAX_A > TIMEOUT_TICKS) ? TMAX_A : TIMEOUT_TICKS;
  localparam int TW     = $clog2(TMAX + 1);

  simon_state_t  state_q, state_d;
  logic [LW-1:0] level_q, level_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [KW-1:0] mem_q [MAX_LEN];
  logic          mem_we;
  logic [15:0]   lfsr;
  logic          lfsr_unused;
  logic [KW-1:0] rnd;
  logic [LW-1:0] last_idx;
  logic          key_ok;
  logic [TW-1:0] show_len, gap_len;

  simon_lfsr #(.SEED(SEED)) u_lfsr (
    .clk  (clk),
    .reset(reset),
    .lfsr (lfsr)
  );

  assign lfsr_unused = ^lfsr[15:KW];

  // Fold the raw LFSR slice into 0..NUM_KEYS-1.
  always_comb begin
    rnd = lfsr[KW-1:0];
    if (int'(lfsr[KW-1:0]) >= NUM_KEYS) rnd = lfsr[KW-1:0] - KW'(NUM_KEYS);
  end

`ifdef SIMON_SPEEDUP_EN
  localparam int SHOW_FAST = (SHOW_TICKS / 2 < 1) ? 1 : SHOW_TICKS / 2;
  localparam int GAP_FAST  = (GAP_TICKS / 2 < 1) ? 1 : GAP_TICKS / 2;
  assign show_len = (level_q > LW'(MAX_LEN / 2)) ? TW'(SHOW_FAST) : TW'(SHOW_TICKS);
  assign gap_len  = (level_q > LW'(MAX_LEN / 2)) ? TW'(GAP_FAST)  : TW'(GAP_TICKS);
`else
  assign show_len = TW'(SHOW_TICKS);
  assign gap_len  = TW'(GAP_TICKS);
`endif

  assign last_idx = level_q - LW'(1);
  assign key_ok   = (int'(key_idx) < NUM_KEYS) && (key_idx == mem_q[idx_q[AW-1:0]]);

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    idx_d   = idx_q;
    tmr_d   = tmr_q;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (start) begin
          state_d = ST_APPEND;
          level_d = '0;
        end
      end
      ST_APPEND: begin
        if (level_q < LW'(MAX_LEN)) begin
          mem_we  = 1'b1;
          level_d = level_q + LW'(1);
        end
        idx_d   = '0;
        tmr_d   = '0;
        state_d = ST_SHOW_ON;
      end
      ST_SHOW_ON: begin
        if (tmr_q == show_len - TW'(1)) begin
          tmr_d   = '0;
          state_d = ST_SHOW_OFF;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      ST_SHOW_OFF: begin
        if (tmr_q == gap_len - TW'(1)) begin
          tmr_d = '0;
          if (idx_q == last_idx) begin
            idx_d   = '0;
            state_d = ST_LISTEN;
          end else begin
            idx_d   = idx_q + LW'(1);
            state_d = ST_SHOW_ON;
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      ST_LISTEN: begin
        // A key in the expiry cycle wins over the timeout.
        if (key_valid) begin
          if (!key_ok) begin
            state_d = ST_LOSE;
          end else if (idx_q == last_idx) begin
            state_d = (level_q == LW'(MAX_LEN)) ? ST_WIN : ST_APPEND;
          end else begin
            idx_d = idx_q + LW'(1);
            tmr_d = '0;
          end
        end else if (tmr_q == TW'(TIMEOUT_TICKS - 1)) begin
          state_d = ST_LOSE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      level_q <= '0;
      idx_q   <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      idx_q   <= idx_d;
      tmr_q   <= tmr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[level_q[AW-1:0]] <= rnd;
  end

  assign show_valid = (state_q == ST_SHOW_ON);
  assign show_idx   = show_valid ? mem_q[idx_q[AW-1:0]] : '0;
  assign simon_turn = (state_q == ST_APPEND) || (state_q == ST_SHOW_ON) ||
                      (state_q == ST_SHOW_OFF);
  assign level      = level_q;
  assign game_over  = (state_q == ST_WIN) || (state_q == ST_LOSE);
  assign win        = (state_q == ST_WIN);

endmodule

`default_nettype wire

// File: tb/tb_simon_seq_engine.sv
// ------------------------------------------------------------------
// tb_simon_seq_engine: three engine configurations checked against a sequence model.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_simon_seq_engine;

`ifdef SIMON_SPEEDUP_EN
  localparam bit SPEED = 1'b1;
`else
  localparam bit SPEED = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic       st [3];
  logic       kv [3];
  logic [1:0] ki [3];
  wire        sv [3];
  wire  [1:0] si [3];
  wire        turn [3];
  wire  [4:0] lv [3];
  wire        go [3];
  wire        wn [3];
  wire  [1:0] lv1;

  int n_chk  = 0;
  int n_pass = 0;
  int seq  [3][16];
  int slen [3];
  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  simon_seq_engine dut0 (
    .clk(clk), .reset(reset), .start(st[0]), .key_valid(kv[0]), .key_idx(ki[0]),
    .show_valid(sv[0]), .show_idx(si[0]), .simon_turn(turn[0]), .level(lv[0]),
    .game_over(go[0]), .win(wn[0])
  );

  simon_seq_engine #(.MAX_LEN(2), .SHOW_TICKS(3), .GAP_TICKS(2)) dut1 (
    .clk(clk), .reset(reset), .start(st[1]), .key_valid(kv[1]), .key_idx(ki[1]),
    .show_valid(sv[1]), .show_idx(si[1]), .simon_turn(turn[1]), .level(lv1),
    .game_over(go[1]), .win(wn[1])
  );
  assign lv[1] = {3'b000, lv1};

  simon_seq_engine #(.NUM_KEYS(3), .SHOW_TICKS(2), .GAP_TICKS(2), .TIMEOUT_TICKS(8)) dut2 (
    .clk(clk), .reset(reset), .start(st[2]), .key_valid(kv[2]), .key_idx(ki[2]),
    .show_valid(sv[2]), .show_idx(si[2]), .simon_turn(turn[2]), .level(lv[2]),
    .game_over(go[2]), .win(wn[2])
  );

  // Reference random source: 16-bit Galois LFSR stepping once per tick.
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  end

  function automatic int nk(input int d);
    return (d == 2) ? 3 : 4;
  endfunction

  function automatic int mlen(input int d);
    return (d == 1) ? 2 : 16;
  endfunction

  function automatic int fast(input int d, input int lvl, input int t);
    if (SPEED && lvl > mlen(d) / 2) return (t / 2 < 1) ? 1 : t / 2;
    return t;
  endfunction

  function automatic int show_t(input int d, input int lvl);
    return fast(d, lvl, (d == 0) ? 30 : (d == 1) ? 3 : 2);
  endfunction

  function automatic int gap_t(input int d, input int lvl);
    return fast(d, lvl, (d == 0) ? 30 : 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic playback(input int d);
    for (int i = 0; i < slen[d]; i++) begin
      for (int t = 0; t < show_t(d, slen[d]); t++) begin
        chk("show_on", sv[d], 1);
        chk("show_idx", si[d], seq[d][i]);
        if (d == 2) chk("idx_range", si[d] < 2'd3, 1);
        tick();
      end
      for (int t = 0; t < gap_t(d, slen[d]); t++) begin
        chk("gap_dark", sv[d], 0);
        chk("gap_idx", si[d], 0);
        chk("gap_turn", turn[d], 1);
        tick();
      end
    end
    chk("listen_turn", turn[d], 0);
    chk("listen_over", go[d], 0);
  endtask

  // Called during the APPEND cycle: the model draws the new step from the LFSR.
  task automatic append(input int d);
    seq[d][slen[d]] = int'(m_lfsr[1:0]) % nk(d);
    slen[d]++;
    tick();
    chk("level", lv[d], slen[d]);
    playback(d);
  endtask

  task automatic start_game(input int d);
    st[d] = 1'b1;
    tick();
    st[d] = 1'b0;
    slen[d] = 0;
    chk("append_turn", turn[d], 1);
    chk("append_dark", sv[d], 0);
    append(d);
  endtask

  task automatic round(input int d);
    for (int k = 0; k < slen[d]; k++) begin
      ki[d] = 2'(seq[d][k]);
      kv[d] = 1'b1;
      tick();
    end
    kv[d] = 1'b0;
    ki[d] = 2'd0;
    if (slen[d] == mlen(d)) begin
      chk("win", wn[d], 1);
      chk("win_over", go[d], 1);
    end else begin
      chk("next_turn", turn[d], 1);
      append(d);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int rounds;
    for (int d = 0; d < 3; d++) begin
      st[d] = 1'b0; kv[d] = 1'b0; ki[d] = 2'd0; slen[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_show_valid", sv[0], 0);
    chk("rst_show_idx", si[0], 0);
    chk("rst_turn", turn[0], 0);
    chk("rst_level", lv[0], 0);
    chk("rst_over", go[0], 0);
    chk("rst_win", wn[0], 0);
    reset = 1'b0;
    tick();

    // Three perfect rounds, level reaches 4 with earlier steps replayed unchanged.
    start_game(0);
    for (int r = 0; r < 3; r++) round(0);
    chk("level4", lv[0], 4);

    // Key in the last allowed cycle keeps the game alive, then a full timeout.
    repeat (119) tick();
    chk("pre_rescue", go[0], 0);
    ki[0] = 2'(seq[0][0]);
    kv[0] = 1'b1;
    tick();
    kv[0] = 1'b0;
    chk("rescued_over", go[0], 0);
    chk("rescued_turn", turn[0], 0);
    repeat (119) tick();
    chk("pre_timeout", go[0], 0);
    tick();
    chk("timeout_over", go[0], 1);
    chk("timeout_win", wn[0], 0);

    // Wrong second key in round 2.
    start_game(0);
    round(0);
    ki[0] = 2'(seq[0][0]);
    kv[0] = 1'b1;
    tick();
    chk("first_ok", go[0], 0);
    ki[0] = 2'((seq[0][1] + 1) % 4);
    tick();
    kv[0] = 1'b0;
    chk("wrong_over", go[0], 1);
    chk("wrong_win", wn[0], 0);

    // Asynchronous reset in the middle of a lit step.
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    repeat (5) tick();
    chk("pre_reset_show", sv[0], 1);
    #2 reset = 1'b1;
    #1;
    chk("areset_show", sv[0], 0);
    chk("areset_level", lv[0], 0);
    chk("areset_turn", turn[0], 0);
    #1 reset = 1'b0;
    tick();
    chk("idle_turn", turn[0], 0);

    // Short game: win at MAX_LEN=2, then restart.
    start_game(1);
    round(1);
    round(1);
    start_game(1);
    chk("restart_level", lv[1], 1);

    // Three-key engine over many rounds.
    rounds = 0;
    while (rounds < 200) begin
      start_game(2);
      for (int g = 0; g < 16; g++) round(2);
      rounds += 16;
    end

    // Out-of-range key loses.
    start_game(2);
    ki[2] = 2'd3;
    kv[2] = 1'b1;
    tick();
    kv[2] = 1'b0;
    chk("badkey_over", go[2], 1);
    chk("badkey_win", wn[2], 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
